// File: rtl/rr_bus_mux_pkg.sv
// Shared types and constants for the SLC-3 round-robin bus multiplexer.
package bus_mux_pkg;

   // Native word width of the SLC-3 datapath buses.
   localparam int BUS_WIDTH = 16;

   // Arbitration policy selected by the mode input.
   typedef enum logic {
      MODE_RR    = 1'b0,
      MODE_FIXED = 1'b1
   } mux_mode_e;

   // Index of the source after idx, wrapping from n-1 back to 0.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_bus_mux_if.sv
// Handshake bundle between NUM_IN producers, the multiplexer and one consumer.
interface rr_bus_mux_if
   import bus_mux_pkg::*;
#(
   parameter int WIDTH  = BUS_WIDTH,
   parameter int NUM_IN = 4,
   localparam int SEL_W = $clog2(NUM_IN)
);

   mux_mode_e                  mode;
   logic [NUM_IN-1:0]          in_valid;
   logic [NUM_IN*WIDTH-1:0]    in_data;
   logic [NUM_IN-1:0]          in_ready;
   logic                       out_valid;
   logic [WIDTH-1:0]           out_data;
   logic [SEL_W-1:0]           out_sel;
   logic                       out_ready;

   // Producer/consumer side: drives requests and the consumer ready.
   modport master (
      output mode, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   // Multiplexer side.
   modport slave (
      input  mode, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

endinterface

// File: rtl/rr_bus_mux_arbiter.sv
// Combinational round-robin / fixed-priority arbiter over NUM_IN requests.
module rr_arbiter
   import bus_mux_pkg::*;
#(
   parameter int NUM_IN = 4,
   localparam int SEL_W = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  mux_mode_e         mode,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_IN-1:0] grant_onehot,
   output logic [SEL_W-1:0]  grant_idx,
   output logic              any_grant
);

   // Scan from the start index (ptr or 0) and grant the first requester found.
   always_comb begin : scan
      int idx;
      // NOTE: every output gets a default first so no path leaves a latch behind.
      grant_onehot = '0;
      grant_idx    = '0;
      any_grant    = 1'b0;
      idx          = 0;
      for (int k = 0; k < NUM_IN; k++) begin
         idx = (mode == MODE_FIXED) ? k : int'(ptr) + k;
         if (idx >= NUM_IN) idx = idx - NUM_IN;
         if (!any_grant && req[idx]) begin
            any_grant         = 1'b1;
            grant_idx         = SEL_W'(idx);
            grant_onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_bus_mux.sv
// Registered N:1 bus multiplexer: arbitrates among sources and holds the
// winning word with its source index until the consumer takes it.
module rr_bus_mux
   import bus_mux_pkg::*;
#(
   parameter int WIDTH  = BUS_WIDTH,
   parameter int NUM_IN = 4,
   localparam int SEL_W = $clog2(NUM_IN)
) (
   input logic         clk,
   input logic         reset,
   rr_bus_mux_if.slave bus
);

   logic [NUM_IN-1:0] grant_onehot;
   logic [SEL_W-1:0]  grant_idx;
   logic              any_grant;
   logic              load;

   logic [SEL_W-1:0]  ptr;
   logic              out_valid_q;
   logic [WIDTH-1:0]  out_data_q;
   logic [SEL_W-1:0]  out_sel_q;

   rr_arbiter #(.NUM_IN(NUM_IN)) u_arbiter (
      .req          (bus.in_valid),
      .mode         (bus.mode),
      .ptr          (ptr),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .any_grant    (any_grant)
   );

   // The output register can take a new word when empty or being drained this
   // cycle; draining and refilling together keeps throughput at one per cycle.
   assign load         = !reset && (!out_valid_q || bus.out_ready);
   assign bus.in_ready = load ? grant_onehot : '0;

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;

   // Output register and round-robin pointer; hold everything under backpressure.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments and all are reset,
      // so a word held at reset is discarded rather than replayed.
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr         <= '0;
      end else if (load) begin
         if (any_grant) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data[grant_idx*WIDTH +: WIDTH];
            out_sel_q   <= grant_idx;
            if (bus.mode == MODE_RR)
               ptr <= SEL_W'(wrap_inc(int'(grant_idx), NUM_IN));
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Directed bench for rr_bus_mux with a queue scoreboard: the stimulus pushes
// the hand-computed word each accepted source should deliver, and a monitor
// pops and compares on every output transfer.
module tb_rr_bus_mux;
   import bus_mux_pkg::*;

   localparam int WIDTH  = 16;
   localparam int NUM_IN = 4;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [1:0]       sel;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic [WIDTH-1:0] words [NUM_IN];

   rr_bus_mux_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

   rr_bus_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_word(input int i, input logic [WIDTH-1:0] v);
      words[i] = v;
      bus.in_data[i*WIDTH +: WIDTH] = v;
   endtask

   // One clock cycle of stimulus: drive, check the same-cycle ready strobe,
   // record the expected word if a source is accepted, then cross the edge.
   task automatic step(input logic [3:0] v, input mux_mode_e m, input logic ordy,
                       input logic [3:0] exp_rdy);
      exp_t e;
      bus.in_valid  = v;
      bus.mode      = m;
      bus.out_ready = ordy;
      #1;
      check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (exp_rdy != 4'b0000) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (exp_rdy[i]) begin
               e.data = words[i];
               e.sel  = 2'(i);
            end
         end
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every transfer to the consumer must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got word 0x%0h sel %0d, expected no transfer (t=%0t)",
                     bus.out_data, bus.out_sel, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", 32'(bus.out_data), 32'(e.data));
            check("out_sel",  32'(bus.out_sel),  32'(e.sel));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset         = 1'b1;
      bus.mode      = MODE_RR;
      bus.in_valid  = 4'b1111;
      bus.out_ready = 1'b1;
      bus.in_data   = '0;
      for (int i = 0; i < NUM_IN; i++) set_word(i, 16'h0000);

      // Reset: no source accepted while reset is high, registers cleared.
      repeat (2) begin
         #1;
         check("reset_in_ready", 32'(bus.in_ready), 32'h0);
         @(posedge clk);
         #1;
      end
      check("reset_out_valid", 32'(bus.out_valid), 32'h0);
      check("reset_out_data",  32'(bus.out_data),  32'h0);
      check("reset_out_sel",   32'(bus.out_sel),   32'h0);
      reset = 1'b0;

      // Single source 2.
      set_word(2, 16'hBEEF);
      step(4'b0100, MODE_RR, 1'b1, 4'b0100);
      check("single_out_valid", 32'(bus.out_valid), 32'h1);
      step(4'b0000, MODE_RR, 1'b1, 4'b0000);
      check("idle_out_valid", 32'(bus.out_valid), 32'h0);
      check("idle_data_hold", 32'(bus.out_data),  32'hBEEF);
      check("idle_sel_hold",  32'(bus.out_sel),   32'h2);

      // Wrap-around: ptr=3 after grant 2, so 0101 grants 0 then 2.
      set_word(0, 16'hA000);
      step(4'b0101, MODE_RR, 1'b1, 4'b0001);
      step(4'b0101, MODE_RR, 1'b1, 4'b0100);
      step(4'b0000, MODE_RR, 1'b1, 4'b0000);

      // Reset to bring ptr back to 0.
      reset = 1'b1;
      bus.in_valid = 4'b1111;
      #1;
      check("reset2_in_ready", 32'(bus.in_ready), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Round-robin fairness, all sources valid.
      for (int i = 0; i < NUM_IN; i++) set_word(i, 16'h1000 + 16'(i));
      step(4'b1111, MODE_RR, 1'b1, 4'b0001);
      step(4'b1111, MODE_RR, 1'b1, 4'b0010);
      step(4'b1111, MODE_RR, 1'b1, 4'b0100);
      step(4'b1111, MODE_RR, 1'b1, 4'b1000);
      step(4'b1111, MODE_RR, 1'b1, 4'b0001);

      // Fixed priority: source 0 always wins, ptr stays at 1.
      repeat (4) step(4'b1111, MODE_FIXED, 1'b1, 4'b0001);

      // Back to round-robin: preserved ptr=1 grants 1, then 2.
      step(4'b1111, MODE_RR, 1'b1, 4'b0010);
      step(4'b1111, MODE_RR, 1'b1, 4'b0100);

      // Backpressure holding 0x1002.
      repeat (3) begin
         step(4'b1111, MODE_RR, 1'b0, 4'b0000);
         check("bp_out_valid", 32'(bus.out_valid), 32'h1);
         check("bp_out_data",  32'(bus.out_data),  32'h1002);
         check("bp_out_sel",   32'(bus.out_sel),   32'h2);
      end
      // Release: consume 0x1002 and refill from source 3 in the same cycle.
      step(4'b1111, MODE_RR, 1'b1, 4'b1000);
      check("refill_out_data", 32'(bus.out_data), 32'h1003);

      // Reset mid-operation with 0x1003 held: the word is discarded.
      reset = 1'b1;
      bus.out_ready = 1'b0;
      #1;
      check("midreset_in_ready", 32'(bus.in_ready), 32'h0);
      @(posedge clk);
      #1;
      exp_q.delete();
      check("midreset_out_valid", 32'(bus.out_valid), 32'h0);
      check("midreset_out_data",  32'(bus.out_data),  32'h0);
      reset = 1'b0;

      // ptr restarted at 0.
      step(4'b1111, MODE_RR, 1'b1, 4'b0001);
      step(4'b0000, MODE_RR, 1'b1, 4'b0000);
      step(4'b0000, MODE_RR, 1'b1, 4'b0000);

      check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_bus_mux.md
Name: rr_bus_mux

Overview:
- Parametrised, registered N:1 bus multiplexer for the SLC-3 datapath.
- Selects one of NUM_IN valid/ready sources using round-robin or fixed-priority arbitration.
- Registers the winning word with its source index for one downstream consumer.
- Replaces hard-wired select muxes wherever several producers contend for one 16-bit bus over multiple cycles.

Parameters:
- WIDTH, 16, data width of each source and of the output bus.
- NUM_IN, 4, number of sources (≥2).
- SEL_W, $clog2(NUM_IN), width of the source-index output (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
- in_valid  input  NUM_IN  per-source request; bit i belongs to source i.
- in_data  input  NUM_IN*WIDTH  packed source words; source i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_IN  one-hot (or zero) accept strobe; combinational.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  SEL_W  index of the source that produced out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer=0.
- While reset=1, in_ready is all zeros, so no source is accepted during the reset cycle.
- Load enable: load = !reset & (!out_valid | out_ready).
- Registers update only when load=1; otherwise they hold.
- Arbitration runs combinationally every cycle on in_valid.
  - Round-robin (mode=0): search indices ptr, ptr+1, …, wrapping modulo NUM_IN; the first valid index wins.
  - Fixed priority (mode=1): the lowest valid index wins; ptr is not updated.
- When load=1 and any in_valid is set, with grant g:
  - in_ready[g]=1 in the same cycle.
  - Next edge: out_data=in_data[g], out_sel=g, out_valid=1.
  - If mode=0: ptr = (g+1) mod NUM_IN, wrapping from NUM_IN-1 to 0.
- When load=1 and no in_valid is set: out_valid=0 next edge; out_data and out_sel hold their old values.
- Latency and throughput:
  - Latency is 1 cycle from acceptance to out_valid.
  - Throughput is 1 word/cycle while out_ready=1.
  - Simultaneous consume-and-refill in the same cycle is required: no bubble.
- Backpressure: out_valid=1 & out_ready=0 → all registers hold, in_ready=0.
- Source rules:
  - Sources hold in_valid and in_data stable until accepted.
  - in_valid must not depend combinationally on in_ready.
  - in_ready depends only on in_valid, mode, ptr, out_valid, out_ready and reset.
- Mode switch mid-traffic takes effect at the next arbitration; ptr is preserved across switches.
- Reset asserted mid-operation discards any held word; the source that would have been granted is not acked.
- At most one in_ready bit is ever high.

Decomposition:
- Package bus_mux_pkg: BUS_WIDTH=16 constant; enum mux_mode_e {MODE_RR=1'b0, MODE_FIXED=1'b1}.
- Sub-module rr_arbiter (params NUM_IN):
  - Inputs: req, mode, ptr.
  - Outputs: grant_onehot, grant_idx, any_grant.
  - Purely combinational.
- The top level owns ptr, the output register and load logic.

Test Plan (NUM_IN=4, WIDTH=16):
- Reset: reset=1 with in_valid=4'b1111 for 2 cycles → in_ready=0000; after the edge out_valid=0, out_data=0x0000, out_sel=0.
- Single source: in_valid=0100, in_data[2]=0xBEEF, out_ready=1 → in_ready=0100 same cycle; next cycle out_valid=1, out_data=0xBEEF, out_sel=2.
- Round-robin fairness: mode=0, all valid, in_data[i]=0x1000+i, out_ready=1 for 5 cycles → out_sel sequence 0,1,2,3,0; out_data 0x1000…0x1003,0x1000.
- Fixed priority: mode=1, all valid, 4 cycles → in_ready=0001 every cycle, out_sel=0 throughout; ptr unchanged.
- Backpressure: out_valid=1 holding 0x1002, out_ready=0 for 3 cycles → out_data stable, in_ready=0000; out_ready=1 → same-cycle in_ready to the next winner, new word next edge.
- Wrap-around: after a grant to source 2 (ptr=3), in_valid=0101 → grant 0 first, then grant 2 on the following load.
